auto_bp_list_buffer: RTL and testbench
======================================

Name: auto_bp_list_buffer

Overview:
- Collects the bad-pixel coordinates that the streaming detector flags during one frame.
- Stores them in a double-buffered (ping-pong) list and exposes the last completed frame's list to the AXI4-Lite detector config slave.
- Feeds the slave's status inputs (frame_detection_done, detected_bp_count, auto_bp_x/y) and serves its indexed readback (auto_bp_read_addr -> auto_bp_read_data).
- Sits between the detector core and the config slave.

Parameters:
- LUT_INDEX_WIDTH, 8, width of the list index.
- LUT_INDEX_NUM, 128, entries per bank; must be ≤ 2^LUT_INDEX_WIDTH.
- COORD_WIDTH, 10, width of each x/y coordinate.

Ports:
- S_AXI_ACLK  in  1  single clock; all logic on rising edge.
- S_AXI_ARESET  in  1  synchronous, active-high reset.
- enable  in  1  go bit from config slave; 0 forces IDLE.
- frame_start  in  1  one-cycle start-of-frame pulse.
- frame_end  in  1  one-cycle end-of-frame pulse.
- bp_valid  in  1  detector flags a bad pixel this cycle.
- bp_x  in  COORD_WIDTH  column of the flagged pixel.
- bp_y  in  COORD_WIDTH  row of the flagged pixel.
- auto_bp_read_addr  in  LUT_INDEX_WIDTH  readback index into the committed bank.
- auto_bp_read_data  out  32  {6'b0, x[9:0], 6'b0, y[9:0]}.
- frame_detection_done  out  1  committed list valid.
- detected_bp_count  out  LUT_INDEX_WIDTH+1  entries in the committed bank.
- auto_bp_x  out  COORD_WIDTH  x of the last accepted entry.
- auto_bp_y  out  COORD_WIDTH  y of the last accepted entry.
- overflow  out  1  committed frame exceeded LUT_INDEX_NUM.

Behaviour:
- Reset:
  - All outputs 0; state IDLE; write bank 0; both bank counts 0.
  - RAM contents are not cleared; reads are gated by count instead.
- States and transitions:
  - IDLE -> WAIT_SOF when enable=1.
  - WAIT_SOF -> COLLECT on frame_start.
  - COLLECT -> WAIT_SOF on frame_end (commit).
  - Any state -> IDLE when enable=0.
  - Entering IDLE clears frame_detection_done, overflow and detected_bp_count, and discards the in-progress list.
- Collect:
  - In COLLECT, or on the frame_start cycle in WAIT_SOF, bp_valid=1 writes {bp_x, bp_y} at wr_cnt in the write bank; wr_cnt increments.
  - auto_bp_x/y update to the accepted coordinates on the next edge.
- Capacity:
  - When wr_cnt == LUT_INDEX_NUM, further bp_valid pulses are dropped, wr_cnt holds, and the frame overflow flag sets.
- Commit, on frame_end in COLLECT (the edge after frame_end):
  - Banks swap.
  - detected_bp_count <= wr_cnt (includes a bp_valid on the frame_end cycle).
  - overflow <= frame overflow flag.
  - frame_detection_done <= 1, held until IDLE.
  - wr_cnt and the frame flag clear.
- Simultaneous events:
  - frame_end and frame_start in the same cycle in COLLECT: commit, then stay in COLLECT with the new frame started.
  - frame_start in COLLECT without a prior frame_end: abort the current frame; wr_cnt and flag clear, no commit, restart collect. A bp_valid in that same cycle becomes entry 0 of the new frame.
  - frame_end in WAIT_SOF or IDLE: ignored.
  - bp_valid outside COLLECT (other than the frame_start cycle): dropped.
- Readback:
  - Registered with 1-cycle latency: auto_bp_read_data at edge n+1 reflects auto_bp_read_addr at edge n, from the committed bank.
  - Returns 0 if addr ≥ detected_bp_count or addr ≥ LUT_INDEX_NUM.
  - The committed bank never changes except at commit. A read during the commit edge returns pre-swap data; the next cycle returns post-swap data.
- Storage:
  - 2×LUT_INDEX_NUM×(2·COORD_WIDTH) simple dual-port RAM.
  - The write address carries the bank select as its MSB; the read address uses the inverted bank select.

Optional Feature:
- AUTO_BP_DEDUP_EN.
- When defined: a bp_valid whose {bp_x, bp_y} equals the last accepted entry of the current frame is dropped, with no count increment and no overflow contribution. The comparison register clears at frame start.
- When undefined: every bp_valid within capacity is stored.

Test Plan:
- Reset, enable=1, frame_start, bp_valid with (5,7), (100,200), (1023,0), frame_end -> next cycle count=3, done=1, overflow=0. Reading addr 1 returns 0x006400C8 one cycle later; addr 3 returns 0.
- 130 bp_valid in one frame with LUT_INDEX_NUM=128 -> after commit count=128, overflow=1, entry 127 holds the 128th coordinate. A following frame with 2 entries -> count=2, overflow=0.
- Frame A (3 entries) committed, then frame B collecting 5 entries while polling addr 0 every cycle -> data stays frame A's entry 0 until the cycle after B's frame_end, then B's entry 0; count goes 3 -> 5.
- frame_start mid-COLLECT after 4 entries, with bp_valid (9,9) in the same cycle, then 1 more entry and frame_end -> count=2, entry 0 = (9,9). Same-cycle frame_end+frame_start commits the previous frame and collects the next.
- enable drops mid-frame -> next cycle done=0, count=0, overflow=0. Assert S_AXI_ARESET mid-COLLECT -> all outputs 0, state IDLE; frame_end in WAIT_SOF is ignored.
- With AUTO_BP_DEDUP_EN: inputs (3,3), (3,3), (4,3), (3,3) -> count=3. Without it -> count=4.

Source files
------------

// File: rtl/auto_bp_list_buffer.sv
// Ping-pong list of detector-flagged bad-pixel coordinates, committed per frame.
// Optional AUTO_BP_DEDUP_EN drops repeats of the last accepted entry in a frame.
module auto_bp_list_buffer #(
    parameter int LUT_INDEX_WIDTH = 8,
    parameter int LUT_INDEX_NUM   = 128,
    parameter int COORD_WIDTH     = 10
) (
    input  logic                       S_AXI_ACLK,
    input  logic                       S_AXI_ARESET,
    input  logic                       enable,
    input  logic                       frame_start,
    input  logic                       frame_end,
    input  logic                       bp_valid,
    input  logic [COORD_WIDTH-1:0]     bp_x,
    input  logic [COORD_WIDTH-1:0]     bp_y,
    input  logic [LUT_INDEX_WIDTH-1:0] auto_bp_read_addr,
    output logic [31:0]                auto_bp_read_data,
    output logic                       frame_detection_done,
    output logic [LUT_INDEX_WIDTH:0]   detected_bp_count,
    output logic [COORD_WIDTH-1:0]     auto_bp_x,
    output logic [COORD_WIDTH-1:0]     auto_bp_y,
    output logic                       overflow
);
    localparam int AW   = (LUT_INDEX_NUM > 1) ? $clog2(LUT_INDEX_NUM) : 1;
    localparam int CW2  = 2 * COORD_WIDTH;
    localparam int PADW = 16 - COORD_WIDTH;
    localparam logic [LUT_INDEX_WIDTH:0] NUM_C = (LUT_INDEX_WIDTH + 1)'(LUT_INDEX_NUM);

    typedef enum logic [1:0] {IDLE, WAIT_SOF, COLLECT} state_t;

    state_t                   state_q, state_d;
    logic                     bank_q, bank_d;
    logic [LUT_INDEX_WIDTH:0] wr_cnt_q, wr_cnt_d;
    logic                     flag_q, flag_d;
    logic [LUT_INDEX_WIDTH:0] count_q, count_d;
    logic                     ovf_q, ovf_d;
    logic                     done_q, done_d;
    logic [COORD_WIDTH-1:0]   x_q, x_d, y_q, y_d;
    logic [31:0]              rd_q;

    logic                     active, restart, commit, dup;
    logic                     accept, drop_full;
    logic [LUT_INDEX_WIDTH:0] base_cnt, cnt_nx;
    logic                     base_flag;
    logic [CW2-1:0]           mem [2**(AW+1)];

`ifdef AUTO_BP_DEDUP_EN
    logic [CW2-1:0] last_q, last_d;
    logic           lvld_q, lvld_d;
    logic           base_lvld;
`endif

    always_comb begin
        state_d   = state_q;
        bank_d    = bank_q;
        wr_cnt_d  = wr_cnt_q;
        flag_d    = flag_q;
        count_d   = count_q;
        ovf_d     = ovf_q;
        done_d    = done_q;
        x_d       = x_q;
        y_d       = y_q;
        active    = 1'b0;
        restart   = 1'b0;
        commit    = 1'b0;
        dup       = 1'b0;
        accept    = 1'b0;
        drop_full = 1'b0;
        base_cnt  = wr_cnt_q;
        base_flag = flag_q;
        cnt_nx    = wr_cnt_q;
`ifdef AUTO_BP_DEDUP_EN
        last_d    = last_q;
        lvld_d    = lvld_q;
        base_lvld = lvld_q;
`endif
        if (!enable) begin
            state_d  = IDLE;
            wr_cnt_d = '0;
            flag_d   = 1'b0;
            count_d  = '0;
            ovf_d    = 1'b0;
            done_d   = 1'b0;
`ifdef AUTO_BP_DEDUP_EN
            lvld_d   = 1'b0;
`endif
        end else begin
            commit  = (state_q == COLLECT) && frame_end;
            restart = frame_start && ((state_q == WAIT_SOF) ||
                      ((state_q == COLLECT) && !frame_end));
            active  = (state_q == COLLECT) ||
                      ((state_q == WAIT_SOF) && frame_start);
            if (restart) begin
                base_cnt  = '0;
                base_flag = 1'b0;
`ifdef AUTO_BP_DEDUP_EN
                base_lvld = 1'b0;
`endif
            end
`ifdef AUTO_BP_DEDUP_EN
            dup = base_lvld && ({bp_x, bp_y} == last_q);
`endif
            accept    = bp_valid && active && !dup && (base_cnt < NUM_C);
            drop_full = bp_valid && active && !dup && (base_cnt >= NUM_C);
            cnt_nx    = base_cnt + {{LUT_INDEX_WIDTH{1'b0}}, accept};
            wr_cnt_d  = cnt_nx;
            flag_d    = base_flag | drop_full;
            if (accept) begin
                x_d = bp_x;
                y_d = bp_y;
            end
`ifdef AUTO_BP_DEDUP_EN
            lvld_d = base_lvld | accept;
            if (accept) last_d = {bp_x, bp_y};
`endif
            // A bp_valid on the frame_end cycle still belongs to the closing frame
            if (commit) begin
                bank_d   = ~bank_q;
                count_d  = cnt_nx;
                ovf_d    = base_flag | drop_full;
                done_d   = 1'b1;
                wr_cnt_d = '0;
                flag_d   = 1'b0;
`ifdef AUTO_BP_DEDUP_EN
                lvld_d   = 1'b0;
`endif
            end
            unique case (state_q)
                IDLE:     state_d = WAIT_SOF;
                WAIT_SOF: state_d = frame_start ? COLLECT : WAIT_SOF;
                COLLECT:  state_d = (frame_end && !frame_start) ? WAIT_SOF : COLLECT;
                default:  state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            state_q  <= IDLE;
            bank_q   <= 1'b0;
            wr_cnt_q <= '0;
            flag_q   <= 1'b0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
`ifdef AUTO_BP_DEDUP_EN
            last_q   <= '0;
            lvld_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            bank_q   <= bank_d;
            wr_cnt_q <= wr_cnt_d;
            flag_q   <= flag_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
            x_q      <= x_d;
            y_q      <= y_d;
`ifdef AUTO_BP_DEDUP_EN
            last_q   <= last_d;
            lvld_q   <= lvld_d;
`endif
        end
    end

    // RAM is never cleared; stale entries are hidden by the count gate
    always_ff @(posedge S_AXI_ACLK) begin
        if (accept) mem[{bank_q, base_cnt[AW-1:0]}] <= {bp_x, bp_y};
    end

    logic [CW2-1:0] rd_word;
    logic           rd_ok;

    always_comb begin
        rd_word = mem[{~bank_q, auto_bp_read_addr[AW-1:0]}];
        rd_ok   = ({1'b0, auto_bp_read_addr} < count_q) &&
                  ({1'b0, auto_bp_read_addr} < NUM_C);
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            rd_q <= '0;
        end else if (rd_ok) begin
            rd_q <= {{PADW{1'b0}}, rd_word[CW2-1:COORD_WIDTH],
                     {PADW{1'b0}}, rd_word[COORD_WIDTH-1:0]};
        end else begin
            rd_q <= '0;
        end
    end

    assign auto_bp_read_data    = rd_q;
    assign frame_detection_done = done_q;
    assign detected_bp_count    = count_q;
    assign auto_bp_x            = x_q;
    assign auto_bp_y            = y_q;
    assign overflow             = ovf_q;

endmodule

// File: tb/tb_auto_bp_list_buffer.sv
// Directed bench for auto_bp_list_buffer; honours AUTO_BP_DEDUP_EN if defined.
module tb_auto_bp_list_buffer;
    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        frame_start;
    logic        frame_end;
    logic        bp_valid;
    logic [9:0]  bp_x;
    logic [9:0]  bp_y;
    logic [7:0]  rd_addr;
    logic [31:0] rd_data;
    logic        done;
    logic [8:0]  count;
    logic [9:0]  ax;
    logic [9:0]  ay;
    logic        ovf;

    int n_run = 0;
    int n_fail = 0;

    auto_bp_list_buffer dut (
        .S_AXI_ACLK           (clk),
        .S_AXI_ARESET         (rst),
        .enable               (enable),
        .frame_start          (frame_start),
        .frame_end            (frame_end),
        .bp_valid             (bp_valid),
        .bp_x                 (bp_x),
        .bp_y                 (bp_y),
        .auto_bp_read_addr    (rd_addr),
        .auto_bp_read_data    (rd_data),
        .frame_detection_done (done),
        .detected_bp_count    (count),
        .auto_bp_x            (ax),
        .auto_bp_y            (ay),
        .overflow             (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic fs, input logic fe, input logic v,
                       input int x, input int y);
        frame_start = fs;
        frame_end   = fe;
        bp_valid    = v;
        bp_x        = 10'(x);
        bp_y        = 10'(y);
        @(posedge clk);
        #1;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        bp_valid    = 1'b0;
    endtask

    task automatic rd(input string tag, input int a, input logic [31:0] exp);
        rd_addr = 8'(a);
        cyc(0, 0, 0, 0, 0);
        check(tag, rd_data, exp);
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; frame_start = 1'b0; frame_end = 1'b0;
        bp_valid = 1'b0; bp_x = '0; bp_y = '0; rd_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_done", 32'(done), 0);
        check("rst_count", 32'(count), 0);
        check("rst_ovf", 32'(ovf), 0);
        check("rst_xy", {ax, ay}, 0);
        check("rst_data", rd_data, 0);

        // basic frame
        enable = 1'b1;
        cyc(0, 0, 0, 0, 0);
        cyc(1, 0, 1, 5, 7);
        cyc(0, 0, 1, 100, 200);
        cyc(0, 0, 1, 1023, 0);
        check("last_xy", {ax, ay}, {12'h0, 10'd1023, 10'd0});
        cyc(0, 1, 0, 0, 0);
        check("f1_count", 32'(count), 3);
        check("f1_done", 32'(done), 1);
        check("f1_ovf", 32'(ovf), 0);
        rd("f1_rd1", 1, 32'h006400C8);
        rd("f1_rd3", 3, 32'h0);
        rd("f1_rd0", 0, 32'h00050007);

        // double buffering while polling addr 0
        rd_addr = 8'd0;
        for (int k = 0; k < 5; k++) begin
            cyc(k == 0, 0, 1, 11 + k, k + 1);
            check("pp_hold", rd_data, 32'h00050007);
        end
        check("pp_cnt_old", 32'(count), 3);
        cyc(0, 1, 0, 0, 0);
        check("pp_commit_rd", rd_data, 32'h00050007);
        check("pp_cnt_new", 32'(count), 5);
        cyc(0, 0, 0, 0, 0);
        check("pp_swap_rd", rd_data, 32'h000B0001);

        // abort by frame_start mid-collect
        cyc(1, 0, 1, 20, 20);
        cyc(0, 0, 1, 21, 21);
        cyc(0, 0, 1, 22, 22);
        cyc(0, 0, 1, 23, 23);
        cyc(1, 0, 1, 9, 9);
        cyc(0, 0, 1, 8, 8);
        cyc(0, 1, 0, 0, 0);
        check("ab_count", 32'(count), 2);
        rd("ab_rd0", 0, 32'h00090009);
        rd("ab_rd1", 1, 32'h00080008);

        // frame_end + frame_start in the same cycle
        cyc(1, 0, 1, 1, 1);
        cyc(0, 0, 1, 2, 2);
        cyc(1, 1, 0, 0, 0);
        check("se_count", 32'(count), 2);
        cyc(0, 0, 1, 3, 3);
        cyc(0, 1, 0, 0, 0);
        check("se_count2", 32'(count), 1);
        rd("se_rd0", 0, 32'h00030003);

        // overflow: 130 entries into 128 slots
        cyc(1, 0, 1, 0, 1);
        for (int i = 1; i < 130; i++) cyc(0, 0, 1, i, i + 1);
        check("of_last_xy", {ax, ay}, {12'h0, 10'd127, 10'd128});
        cyc(0, 1, 0, 0, 0);
        check("of_count", 32'(count), 128);
        check("of_ovf", 32'(ovf), 1);
        rd("of_rd127", 127, 32'h007F0080);
        rd("of_rd128", 128, 32'h0);

        // enable drop mid-frame
        cyc(1, 0, 1, 50, 50);
        enable = 1'b0;
        cyc(0, 0, 1, 51, 51);
        check("en_done", 32'(done), 0);
        check("en_count", 32'(count), 0);
        check("en_ovf", 32'(ovf), 0);
        enable = 1'b1;
        cyc(0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        check("ws_fe_done", 32'(done), 0);
        cyc(1, 0, 1, 30, 31);
        cyc(0, 0, 1, 32, 33);
        cyc(0, 1, 0, 0, 0);
        check("f2_count", 32'(count), 2);
        check("f2_ovf", 32'(ovf), 0);

        // dedup pattern
        cyc(1, 0, 1, 3, 3);
        cyc(0, 0, 1, 3, 3);
        cyc(0, 0, 1, 4, 3);
        cyc(0, 0, 1, 3, 3);
        cyc(0, 1, 0, 0, 0);
`ifdef AUTO_BP_DEDUP_EN
        check("dd_count", 32'(count), 3);
`else
        check("dd_count", 32'(count), 4);
`endif

        // reset mid-collect, then IDLE ignores frame_start
        cyc(1, 0, 1, 60, 61);
        rst = 1'b1;
        cyc(0, 0, 1, 62, 62);
        rst = 1'b0;
        check("mr_done", 32'(done), 0);
        check("mr_count", 32'(count), 0);
        check("mr_ovf", 32'(ovf), 0);
        check("mr_xy", {ax, ay}, 0);
        check("mr_data", rd_data, 0);
        cyc(1, 0, 1, 6, 6);
        check("idle_drop", {ax, ay}, 0);
        cyc(0, 1, 0, 0, 0);
        check("ws_fe2_done", 32'(done), 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
